// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access / write-back pipeline stage.
//
// Accepts one retired instruction at a time from execute. ALU-only
// instructions are written back on the next cycle. Loads and stores are
// issued to a ready-handshaked data memory while execute is stalled.
// Each instruction that writes a register produces exactly one
// single-cycle register-file write. Register 15 (PC) is never written.
//
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a memory
// access that waits TIMEOUT cycles without mem_ready is abandoned and
// mem_err pulses for one cycle.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   exe_*            instruction from execute (valid/ready handshake)
//   mem_req/we/addr/wdata, mem_rdata/ready   data memory port
//   mem_err          timeout pulse (0 unless MEM_TIMEOUT_EN)
//   wb_en, dest_wb, result_wb                register-file write port
module mem_wb_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_valid,
  output logic             exe_ready,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             exe_mem_w_en,
  input  logic [3:0]       exe_dest,
  input  logic [WIDTH-1:0] exe_alu_res,
  input  logic [WIDTH-1:0] exe_st_val,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_err,
  output logic             wb_en,
  output logic [3:0]       dest_wb,
  output logic [WIDTH-1:0] result_wb
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t           state_reg, state_next;
  logic             mem_we_reg, mem_we_next;
  logic [WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]       mem_dest_reg, mem_dest_next;
  logic             mem_wb_flag_reg, mem_wb_flag_next;
  logic             wb_en_reg, wb_en_next;
  logic [3:0]       dest_wb_reg, dest_wb_next;
  logic [WIDTH-1:0] result_wb_reg, result_wb_next;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_reg, cnt_next;
  logic       mem_err_reg, mem_err_next;
`endif

  always_comb begin
    state_next       = state_reg;
    mem_we_next      = mem_we_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    mem_dest_next    = mem_dest_reg;
    mem_wb_flag_next = mem_wb_flag_reg;
    wb_en_next       = 1'b0;
    dest_wb_next     = dest_wb_reg;
    result_wb_next   = result_wb_reg;
`ifdef MEM_TIMEOUT_EN
    cnt_next         = cnt_reg;
    mem_err_next     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (exe_valid) begin
          if (exe_mem_r_en || exe_mem_w_en) begin
            state_next       = MEM;
            mem_addr_next    = exe_alu_res;
            mem_wdata_next   = exe_st_val;
            mem_we_next      = exe_mem_w_en;
            mem_dest_next    = exe_dest;
            mem_wb_flag_next = exe_wb_en;
`ifdef MEM_TIMEOUT_EN
            cnt_next         = 8'd0;
`endif
          end else begin
            wb_en_next     = exe_wb_en && (exe_dest != 4'd15);
            dest_wb_next   = exe_dest;
            result_wb_next = exe_alu_res;
          end
        end
      end
      MEM: begin
        if (mem_ready) begin
          state_next = IDLE;
          // A store (including load+store, where the store wins) never
          // writes back.
          if (!mem_we_reg) begin
            wb_en_next     = mem_wb_flag_reg && (mem_dest_reg != 4'd15);
            dest_wb_next   = mem_dest_reg;
            result_wb_next = mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_reg == TIMEOUT_LAST) begin
          // Abandon the access: back to IDLE with no write-back.
          state_next   = IDLE;
          mem_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_dest_reg    <= 4'd0;
      mem_wb_flag_reg <= 1'b0;
      wb_en_reg       <= 1'b0;
      dest_wb_reg     <= 4'd0;
      result_wb_reg   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg         <= 8'd0;
      mem_err_reg     <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      mem_we_reg      <= mem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      mem_dest_reg    <= mem_dest_next;
      mem_wb_flag_reg <= mem_wb_flag_next;
      wb_en_reg       <= wb_en_next;
      dest_wb_reg     <= dest_wb_next;
      result_wb_reg   <= result_wb_next;
`ifdef MEM_TIMEOUT_EN
      cnt_reg         <= cnt_next;
      mem_err_reg     <= mem_err_next;
`endif
    end
  end

  // Handshake and request are decoded straight from the state flop.
  assign exe_ready = (state_reg == IDLE);
  assign mem_req   = (state_reg == MEM);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign wb_en     = wb_en_reg;
  assign dest_wb   = dest_wb_reg;
  assign result_wb = result_wb_reg;
`ifdef MEM_TIMEOUT_EN
  assign mem_err   = mem_err_reg;
`else
  assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage (default build, no timeout).
// Expected register writes are pushed to a scoreboard queue when an
// instruction is issued and popped by a monitor whenever wb_en is seen.
module tb_mem_wb_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         exe_valid, exe_ready, exe_wb_en, exe_mem_r_en, exe_mem_w_en;
  logic [3:0]   exe_dest;
  logic [W-1:0] exe_alu_res, exe_st_val;
  logic         mem_req, mem_we, mem_ready, mem_err;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         wb_en;
  logic [3:0]   dest_wb;
  logic [W-1:0] result_wb;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];   // {dest, data}

  mem_wb_stage #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_dest(exe_dest),
    .exe_alu_res(exe_alu_res), .exe_st_val(exe_st_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_err(mem_err), .wb_en(wb_en), .dest_wb(dest_wb),
    .result_wb(result_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Write-back monitor: every wb_en must match the oldest expectation.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", {60'd0, dest_wb}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("dest_wb", {60'd0, dest_wb}, {60'd0, e[35:32]});
          chk("result_wb", {32'd0, result_wb}, {32'd0, e[31:0]});
          $display("wb dest=%0d data=%08h", dest_wb, result_wb);
        end
      end
    end
  end

  // Present one instruction for one edge; queue its expected write-back.
  task automatic issue(input logic wb, input logic r, input logic w,
                       input logic [3:0] d, input logic [W-1:0] alu,
                       input logic [W-1:0] st);
    @(negedge clk);
    chk("exe_ready_issue", {63'd0, exe_ready}, 64'd1);
    exe_valid = 1'b1; exe_wb_en = wb; exe_mem_r_en = r; exe_mem_w_en = w;
    exe_dest = d; exe_alu_res = alu; exe_st_val = st;
    if (!r && !w && wb && d != 4'd15) sb.push_back({d, alu});
    $display("issue wb=%0b r=%0b w=%0b dest=%0d alu=%08h st=%08h",
             wb, r, w, d, alu, st);
    @(posedge clk);
    #1 exe_valid = 1'b0;
  endtask

  // Service an outstanding request after `waits` stall cycles.
  task automatic serve(input int waits, input logic [W-1:0] rd,
                       input logic we, input logic [W-1:0] a,
                       input logic [W-1:0] wd, input logic lw,
                       input logic [3:0] d);
    if (!we && lw && d != 4'd15) sb.push_back({d, rd});
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("mem_req", {63'd0, mem_req}, 64'd1);
      chk("exe_ready_mem", {63'd0, exe_ready}, 64'd0);
      chk("mem_we", {63'd0, mem_we}, {63'd0, we});
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, a});
      chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rd : $urandom;
      @(posedge clk);
      #1 mem_ready = 1'b0;
    end
    $display("mem done we=%0b addr=%08h waits=%0d", we, a, waits);
    @(negedge clk);
    chk("mem_req_drop", {63'd0, mem_req}, 64'd0);
    chk("exe_ready_after", {63'd0, exe_ready}, 64'd1);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [3:0]   d;
    logic [W-1:0] v, a;
    logic         ld, wb;
    int           wt;
    rst = 1'b0; exe_valid = 1'b1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b0;
    exe_mem_w_en = 1'b0; exe_dest = 4'd2; exe_alu_res = 32'h5;
    exe_st_val = 32'h0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset held for two edges with valid asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_err", {63'd0, mem_err}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_dest_wb", {60'd0, dest_wb}, 64'd0);
    chk("rst_result_wb", {32'd0, result_wb}, 64'd0);
    chk("rst_exe_ready", {63'd0, exe_ready}, 64'd1);
    $display("reset checked");
    exe_valid = 1'b0; rst = 1'b1;

    // ALU back-to-back.
    issue(1, 0, 0, 4'd3, 32'h11, 0);
    issue(1, 0, 0, 4'd4, 32'h22, 0);
    drain("sb_alu");

    // Load with 3 wait states.
    issue(1, 1, 0, 4'd6, 32'h100, 0);
    serve(3, 32'hCAFE, 0, 32'h100, 32'h0, 1, 4'd6);
    drain("sb_load");

    // Zero-wait store: no write-back.
    issue(1, 0, 1, 4'd0, 32'h40, 32'h55);
    serve(0, 32'h0, 1, 32'h40, 32'h55, 1, 4'd0);
    drain("sb_store");

    // Load+store together: store wins, no write-back.
    issue(1, 1, 1, 4'd7, 32'h80, 32'h99);
    serve(1, 32'h1234, 1, 32'h80, 32'h99, 1, 4'd7);

    // Register 15 never written, by ALU or load; wb_en=0 ALU writes nothing.
    issue(1, 0, 0, 4'd15, 32'h77, 0);
    issue(1, 1, 0, 4'd15, 32'h10, 0);
    serve(0, 32'hBEEF, 0, 32'h10, 32'h0, 1, 4'd15);
    issue(0, 0, 0, 4'd5, 32'h66, 0);
    drain("sb_r15");

    // mem_ready while idle is ignored.
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hDEAD;
    repeat (2) @(negedge clk);
    chk("idle_ready_req", {63'd0, mem_req}, 64'd0);
    mem_ready = 1'b0;
    drain("sb_idle_ready");

    // Random mix of ALU ops and loads.
    for (int n = 0; n < 20; n++) begin
      d = 4'($urandom_range(0, 15)); v = $urandom; a = $urandom;
      ld = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 3) != 0);
      wt = $urandom_range(0, 3);
      if (ld) begin
        issue(wb, 1, 0, d, a, 0);
        serve(wt, v, 0, a, 32'h0, wb, d);
      end else begin
        issue(wb, 0, 0, d, v, 0);
      end
    end
    drain("sb_random");

    // Reset in the middle of a load: request abandoned, no write-back.
    issue(1, 1, 0, 4'd9, 32'h200, 0);
    @(negedge clk);
    chk("mid_mem_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {63'd0, mem_req}, 64'd0);
    chk("mid_rst_ready", {63'd0, exe_ready}, 64'd1);
    chk("mid_rst_addr", {32'd0, mem_addr}, 64'd0);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h9999;
    @(negedge clk); mem_ready = 1'b0;
    drain("sb_mid_rst");
    chk("mem_err_final", {63'd0, mem_err}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
